// File: rtl/param_pattern_generator_pkg.sv
// Shared definitions for the pattern generator: colour-index and mode encodings,
// the two 8-bit palettes, and small sizing helpers.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDX_A = 2'b00,
    IDX_B = 2'b01,
    IDX_C = 2'b10,
    IDX_D = 2'b11
  } color_idx_e;

  typedef enum logic [1:0] {
    MODE_TILES  = 2'd0,
    MODE_SOLID  = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_INVERT = 2'd3
  } mode_e;

  localparam logic [23:0] PAL0_A = 24'h8e44ad;
  localparam logic [23:0] PAL0_B = 24'h2c3e50;
  localparam logic [23:0] PAL0_C = 24'h16a085;
  localparam logic [23:0] PAL0_D = 24'h2980b9;

  localparam logic [23:0] PAL1_A = 24'h1abc9c;
  localparam logic [23:0] PAL1_B = 24'he67e22;
  localparam logic [23:0] PAL1_C = 24'hf1c40f;
  localparam logic [23:0] PAL1_D = 24'h2ecc71;

  function automatic logic [23:0] palette_rgb(input logic pal_sel, input color_idx_e idx);
    logic [23:0] rgb;
    if (pal_sel) begin
      case (idx)
        IDX_B:   rgb = PAL1_B;
        IDX_C:   rgb = PAL1_C;
        IDX_D:   rgb = PAL1_D;
        default: rgb = PAL1_A;
      endcase
    end else begin
      case (idx)
        IDX_B:   rgb = PAL0_B;
        IDX_C:   rgb = PAL0_C;
        IDX_D:   rgb = PAL0_D;
        default: rgb = PAL0_A;
      endcase
    end
    return rgb;
  endfunction

  // Counter width for a range of n values; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_pattern_generator_if.sv
// Pixel stream bus between the pattern generator (master) and its consumer (slave).
// The StartOfFrame/EndOfLine flags exist only when PATTERN_GEN_SYNC_FLAGS_EN is defined.
interface param_pattern_generator_if #(
  parameter int COLOR_W = 8
);
  logic                 VideoValid;
  logic                 VideoReady;
  logic [3*COLOR_W-1:0] Video;
`ifdef PATTERN_GEN_SYNC_FLAGS_EN
  logic                 StartOfFrame;
  logic                 EndOfLine;
`endif

  modport master (
`ifdef PATTERN_GEN_SYNC_FLAGS_EN
    output StartOfFrame,
    output EndOfLine,
`endif
    output VideoValid,
    output Video,
    input  VideoReady
  );

  modport slave (
`ifdef PATTERN_GEN_SYNC_FLAGS_EN
    input  StartOfFrame,
    input  EndOfLine,
`endif
    input  VideoValid,
    input  Video,
    output VideoReady
  );

endinterface

// File: rtl/param_pattern_generator_raster_counter.sv
// Raster position counter: x/y, tile-column/row parities and frame/palette tracking.
// Exposes the next-state position so the owner can register pixels in step with it.
module raster_counter
  import pattern_gen_pkg::*;
#(
  parameter int  H_ACTIVE           = 800,
  parameter int  V_ACTIVE           = 600,
  parameter int  TILE_W             = 80,
  parameter int  TILE_H             = 50,
  parameter int  FRAMES_PER_PALETTE = 72,
  localparam int XW                 = cnt_w(H_ACTIVE),
  localparam int YW                 = cnt_w(V_ACTIVE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  output logic [XW-1:0] x_d_o,
  output logic [YW-1:0] y_d_o,
  output logic          tx_par_d_o,
  output logic          ty_par_d_o,
  output logic          pal_d_o
);

  localparam int CW = cnt_w(TILE_W);
  localparam int RW = cnt_w(TILE_H);
  localparam int FW = cnt_w(FRAMES_PER_PALETTE);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          txp_q, txp_d;
  logic          typ_q, typ_d;
  logic          pal_q, pal_d;

  // Tile parity is tracked incrementally so no divider by TILE_W/TILE_H is needed.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    row_d = row_q;
    frm_d = frm_q;
    txp_d = txp_q;
    typ_d = typ_q;
    pal_d = pal_q;
    if (adv_i) begin
      if (x_q == XW'(H_ACTIVE - 1)) begin
        x_d   = '0;
        col_d = '0;
        txp_d = 1'b0;
        if (y_q == YW'(V_ACTIVE - 1)) begin
          y_d   = '0;
          row_d = '0;
          typ_d = 1'b0;
          if (frm_q == FW'(FRAMES_PER_PALETTE - 1)) begin
            frm_d = '0;
            pal_d = ~pal_q;
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end else begin
          y_d = y_q + 1'b1;
          if (row_q == RW'(TILE_H - 1)) begin
            row_d = '0;
            typ_d = ~typ_q;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end else begin
        x_d = x_q + 1'b1;
        if (col_q == CW'(TILE_W - 1)) begin
          col_d = '0;
          txp_d = ~txp_q;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
      row_q <= '0;
      frm_q <= '0;
      txp_q <= 1'b0;
      typ_q <= 1'b0;
      pal_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
      row_q <= row_d;
      frm_q <= frm_d;
      txp_q <= txp_d;
      typ_q <= typ_d;
      pal_q <= pal_d;
    end
  end

  assign x_d_o      = x_d;
  assign y_d_o      = y_d;
  assign tx_par_d_o = txp_d;
  assign ty_par_d_o = typ_d;
  assign pal_d_o    = pal_d;

endmodule

// File: rtl/param_pattern_generator.sv
// Parameterised test-pattern source on a valid/ready pixel bus (tiles, solid, ramp, inverse).
// Optional sync flags on the bus are enabled by defining PATTERN_GEN_SYNC_FLAGS_EN.
module param_pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE           = 800,
  parameter int V_ACTIVE           = 600,
  parameter int TILE_W             = 80,
  parameter int TILE_H             = 50,
  parameter int COLOR_W            = 8,
  parameter int FRAMES_PER_PALETTE = 72
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [1:0]                       Mode,
  param_pattern_generator_if.master        vid
);

  localparam int XW  = cnt_w(H_ACTIVE);
  localparam int YW  = cnt_w(V_ACTIVE);
  localparam int PW  = 3 * COLOR_W;
  localparam int SHR = (COLOR_W < 8) ? 8 - COLOR_W : 0;
  localparam int SHL = (COLOR_W > 8) ? COLOR_W - 8 : 0;

  logic          vld_q;
  logic [PW-1:0] video_q, video_d;
  mode_e         mode_q, mode_d;
  logic [PW-1:0] tile_rgb;
  logic          adv, load, frame_start;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic          txp_d, typ_d, pal_d;

  function automatic logic [COLOR_W-1:0] scale8(input logic [7:0] c);
    logic [31:0] w;
    w = ({24'd0, c} >> SHR) << SHL;
    return w[COLOR_W-1:0];
  endfunction

  function automatic logic [PW-1:0] scale_rgb(input logic [23:0] rgb);
    return {scale8(rgb[23:16]), scale8(rgb[15:8]), scale8(rgb[7:0])};
  endfunction

  function automatic logic [PW-1:0] grey_ramp(input logic [XW-1:0] x);
    logic [31:0]        xw;
    logic [COLOR_W-1:0] g;
    xw = 32'(x);
    g  = xw[COLOR_W-1:0];
    return {g, g, g};
  endfunction

  // The register stage loads whenever the presented pixel is consumed or not yet valid,
  // so Video always tracks the counter's next position with no bubble.
  assign adv  = vld_q & vid.VideoReady;
  assign load = ~vld_q | adv;

  raster_counter #(
    .H_ACTIVE           (H_ACTIVE),
    .V_ACTIVE           (V_ACTIVE),
    .TILE_W             (TILE_W),
    .TILE_H             (TILE_H),
    .FRAMES_PER_PALETTE (FRAMES_PER_PALETTE)
  ) u_raster (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .adv_i      (adv),
    .x_d_o      (x_d),
    .y_d_o      (y_d),
    .tx_par_d_o (txp_d),
    .ty_par_d_o (typ_d),
    .pal_d_o    (pal_d)
  );

  always_comb begin
    frame_start = (x_d == '0) && (y_d == '0);
    mode_d      = frame_start ? mode_e'(Mode) : mode_q;
    tile_rgb    = scale_rgb(palette_rgb(pal_d, color_idx_e'({typ_d, txp_d})));
    video_d     = tile_rgb;
    case (mode_d)
      MODE_SOLID:  video_d = scale_rgb(palette_rgb(pal_d, IDX_A));
      MODE_RAMP:   video_d = grey_ramp(x_d);
      MODE_INVERT: video_d = ~tile_rgb;
      default:     video_d = tile_rgb;
    endcase
  end

  // Output stage: pixel, mode latch and valid.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_q   <= 1'b0;
      video_q <= '0;
      mode_q  <= MODE_TILES;
    end else begin
      vld_q <= 1'b1;
      if (load) begin
        video_q <= video_d;
        mode_q  <= mode_d;
      end
    end
  end

  assign vid.VideoValid = vld_q;
  assign vid.Video      = video_q;

`ifdef PATTERN_GEN_SYNC_FLAGS_EN
  logic sof_q, eol_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else if (load) begin
      sof_q <= frame_start;
      eol_q <= (x_d == XW'(H_ACTIVE - 1));
    end
  end

  assign vid.StartOfFrame = sof_q;
  assign vid.EndOfLine    = eol_q;
`endif

endmodule

// File: tb/tb_param_pattern_generator.sv
// Directed bench for param_pattern_generator using three differently-sized instances.
module tb_param_pattern_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int pos    = 0;

  logic       rst1 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
  logic [1:0] mode1 = 2'd0, mode2 = 2'd0, mode3 = 2'd0;

  param_pattern_generator_if #(.COLOR_W(8)) bus1 ();
  param_pattern_generator_if #(.COLOR_W(8)) bus2 ();
  param_pattern_generator_if #(.COLOR_W(4)) bus3 ();

  param_pattern_generator #(
    .H_ACTIVE(160), .V_ACTIVE(100), .TILE_W(80), .TILE_H(50),
    .COLOR_W(8), .FRAMES_PER_PALETTE(72)
  ) dut_big (.Clock(clk), .Reset(rst1), .Mode(mode1), .vid(bus1));

  param_pattern_generator #(
    .H_ACTIVE(16), .V_ACTIVE(4), .TILE_W(4), .TILE_H(2),
    .COLOR_W(8), .FRAMES_PER_PALETTE(72)
  ) dut_small (.Clock(clk), .Reset(rst2), .Mode(mode2), .vid(bus2));

  param_pattern_generator #(
    .H_ACTIVE(16), .V_ACTIVE(4), .TILE_W(4), .TILE_H(2),
    .COLOR_W(4), .FRAMES_PER_PALETTE(1)
  ) dut_narrow (.Clock(clk), .Reset(rst3), .Mode(mode3), .vid(bus3));

  typedef struct {
    int          frame;
    logic [1:0]  mode;
    int          x;
    int          y;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

`ifdef PATTERN_GEN_SYNC_FLAGS_EN
  int sof_bad = 0, eol_bad = 0, sof_cnt = 0, eol_cnt = 0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.VideoReady = 1'b1;
    bus2.VideoReady = 1'b1;
    bus3.VideoReady = 1'b1;

    // 4-bit palette entries are the top nibble of each 8-bit channel.
    vecs[0]  = '{0, 2'd0,  0, 0, 12'h84a};
    vecs[1]  = '{0, 2'd0,  4, 0, 12'h235};
    vecs[2]  = '{0, 2'd0,  8, 0, 12'h84a};
    vecs[3]  = '{0, 2'd0,  4, 2, 12'h28b};
    vecs[4]  = '{0, 2'd0,  0, 3, 12'h1a8};
    vecs[5]  = '{1, 2'd0,  0, 0, 12'h1b9};
    vecs[6]  = '{1, 2'd0, 12, 1, 12'he72};
    vecs[7]  = '{1, 2'd1,  5, 2, 12'h1b9};
    vecs[8]  = '{2, 2'd1, 13, 3, 12'h84a};
    vecs[9]  = '{1, 2'd2,  5, 0, 12'h555};
    vecs[10] = '{1, 2'd2, 15, 3, 12'hfff};
    vecs[11] = '{1, 2'd3,  4, 2, 12'hd38};
    vecs[12] = '{2, 2'd3,  0, 0, 12'h7b5};

    // Large-tile instance: reset, tile map, backpressure, mode change, mid-frame reset.
    step(3);
    chk("reset_valid", 32'(bus1.VideoValid), 32'd0);
    chk("reset_video", 32'(bus1.Video), 32'd0);
    rst1 = 1'b0;
    step(1);
    chk("first_valid", 32'(bus1.VideoValid), 32'd1);
    chk("px0_A", 32'(bus1.Video), 32'h8e44ad);
    step(79);
    chk("px79_A", 32'(bus1.Video), 32'h8e44ad);
    bus1.VideoReady = 1'b0;
    step(10);
    chk("stall_video", 32'(bus1.Video), 32'h8e44ad);
    chk("stall_valid", 32'(bus1.VideoValid), 32'd1);
    bus1.VideoReady = 1'b1;
    step(1);
    chk("px80_B", 32'(bus1.Video), 32'h2c3e50);
    step(7920);
    chk("line50_px0_C", 32'(bus1.Video), 32'h16a085);
    step(80);
    chk("line50_px80_D", 32'(bus1.Video), 32'h2980b9);
    step(1620);
    mode1 = 2'd2;
    step(3250);
    chk("midframe_mode_held", 32'(bus1.Video), 32'h2980b9);
    step(3050);
    chk("next_frame_ramp_px0", 32'(bus1.Video), 32'h000000);
    step(5);
    chk("next_frame_ramp_px5", 32'(bus1.Video), 32'h050505);
    mode1 = 2'd0;
    step(7318);
    chk("ramp_px123_line45", 32'(bus1.Video), 32'h7b7b7b);
    rst1 = 1'b1;
    step(1);
    chk("midframe_reset_valid", 32'(bus1.VideoValid), 32'd0);
    chk("midframe_reset_video", 32'(bus1.Video), 32'd0);
    rst1 = 1'b0;
    step(1);
    chk("post_reset_px0", 32'(bus1.Video), 32'h8e44ad);
    step(80);
    chk("post_reset_px80", 32'(bus1.Video), 32'h2c3e50);

    // Small instance: sync flags and palette alternation over 144 frames.
    step(1);
    rst2 = 1'b0;
    step(1);
    chk("small_f0_px0", 32'(bus2.Video), 32'h8e44ad);
`ifdef PATTERN_GEN_SYNC_FLAGS_EN
    for (int k = 0; k < 128; k++) begin
      if (bus2.StartOfFrame !== ((k % 64) == 0)) sof_bad++;
      if (bus2.EndOfLine !== ((k % 16) == 15)) eol_bad++;
      if (bus2.StartOfFrame === 1'b1) sof_cnt++;
      if (bus2.EndOfLine === 1'b1) eol_cnt++;
      step(1);
    end
    pos = 128;
    chk("sof_pattern_errors", 32'(sof_bad), 32'd0);
    chk("eol_pattern_errors", 32'(eol_bad), 32'd0);
    chk("sof_pulses_128", 32'(sof_cnt), 32'd2);
    chk("eol_pulses_128", 32'(eol_cnt), 32'd8);
    step(15);
    pos = 143;
    bus2.VideoReady = 1'b0;
    step(3);
    chk("eol_held_stall", 32'(bus2.EndOfLine), 32'd1);
    chk("sof_low_stall", 32'(bus2.StartOfFrame), 32'd0);
    bus2.VideoReady = 1'b1;
    step(1);
    pos = 144;
    chk("eol_after_stall", 32'(bus2.EndOfLine), 32'd0);
`endif
    step(4607 - pos);
    chk("f71_last_px_D", 32'(bus2.Video), 32'h2980b9);
    step(1);
    chk("f72_px0_pal1", 32'(bus2.Video), 32'h1abc9c);
    step(72 * 64);
    chk("f144_px0_pal0", 32'(bus2.Video), 32'h8e44ad);

    // Narrow-colour instance: table of mode/palette/position vectors.
    for (int i = 0; i < 13; i++) begin
      rst3  = 1'b1;
      mode3 = 2'd0;
      step(2);
      rst3 = 1'b0;
      step(1);
      mode3 = vecs[i].mode;
      step(vecs[i].frame * 64 + vecs[i].y * 16 + vecs[i].x);
      chk($sformatf("narrow_vec%0d", i), 32'(bus3.Video), 32'(vecs[i].exp));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/param_pattern_generator.md
PARAM_PATTERN_GENERATOR -- requirements
Module: param_pattern_generator

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 600, meaning lines per frame.
REQ-003 SHALL have parameter TILE_W, default 80, meaning tile width in pixels.
REQ-004 SHALL have parameter TILE_H, default 50, meaning tile height in lines.
REQ-005 SHALL have parameter COLOR_W, default 8, meaning bits per colour channel.
REQ-006 SHALL have parameter FRAMES_PER_PALETTE, default 72, meaning frames shown before the palette switches.
REQ-007 SHALL have port Clock, input, 1 bit: the single clock.
REQ-008 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port Mode, input, 2 bits: pattern select, sampled at frame start.
REQ-010 SHALL have port VideoReady, input, 1 bit: consumer accepts a pixel.
REQ-011 SHALL have port VideoValid, output, 1 bit: Video holds a valid pixel.
REQ-012 SHALL have port Video, output, 3*COLOR_W bits: pixel as {R,G,B}.
REQ-013 SHALL have ports StartOfFrame and EndOfLine, output, 1 bit each, present only under PATTERN_GEN_SYNC_FLAGS_EN.

Function
REQ-014 SHALL keep pixel counter x (0..H_ACTIVE-1) and line counter y (0..V_ACTIVE-1); both advance only on a transfer (VideoValid && VideoReady).
REQ-015 SHALL wrap x to 0 and increment y when a transfer occurs at x=H_ACTIVE-1; SHALL wrap y to 0 and increment the frame count when that also occurs at y=V_ACTIVE-1.
REQ-016 SHALL hold Video, x, y and the frame count stable while VideoValid=1 and VideoReady=0.
REQ-017 SHALL derive colour index {ty[0],tx[0]}, with tx=x/TILE_W and ty=y/TILE_H, selecting palette entries 00=A, 01=B, 10=C, 11=D.
REQ-018 SHALL provide palette 0: A=8e44ad, B=2c3e50, C=16a085, D=2980b9.
REQ-019 SHALL provide palette 1: A=1abc9c, B=e67e22, C=f1c40f, D=2ecc71.
REQ-020 SHALL use palette 0 for frames 0..FRAMES_PER_PALETTE-1 and palette 1 for the next FRAMES_PER_PALETTE frames, then alternate indefinitely.
REQ-021 SHALL produce these Mode patterns: 0 = tiles per REQ-017; 1 = solid entry A; 2 = grey ramp with every channel = x[COLOR_W-1:0]; 3 = bitwise inverse of mode 0.
REQ-022 SHALL latch Mode only on the first pixel of a frame (x=0, y=0); changes mid-frame take effect at the next frame.
REQ-023 SHALL register Video so that it always reflects the current (x,y), with no bubble between consecutive transfers.
REQ-024 SHALL hold VideoValid at 1 in every cycle after reset is released; the generator never stalls itself.
REQ-025 SHALL round the palette colours to COLOR_W bits by taking the top COLOR_W bits of each 8-bit value when COLOR_W<8, and by left-shifting with zero fill when COLOR_W>8.

Reset
REQ-026 SHALL force VideoValid=0, Video=0, x=0, y=0, frame count=0, palette=0 and latched Mode=0 while Reset=1, including a Reset asserted mid-frame.
REQ-027 SHALL drive VideoValid=1 and Video=palette 0 entry A for the latched Mode in the first cycle after Reset falls, with Mode sampled in that cycle.

Configuration
REQ-028 SHALL, with PATTERN_GEN_SYNC_FLAGS_EN defined, assert StartOfFrame while the presented pixel is (0,0) and EndOfLine while x=H_ACTIVE-1; both are aligned with Video and held under backpressure.
REQ-029 SHALL, without PATTERN_GEN_SYNC_FLAGS_EN, omit those ports and their logic entirely.

Structure
REQ-030 SHALL place the palette constants, the colour-index typedef and the Mode encodings in the shared package pattern_gen_pkg.
REQ-031 SHALL implement the x/y/frame counting in one sub-module, raster_counter, with an advance-enable input.

Verification
REQ-032 SHALL check: Reset for 1 cycle, Mode=0, VideoReady=1 -> pixel 0 is 8e44ad, pixel 80 is 2c3e50, line 50 pixel 0 is 16a085, line 50 pixel 80 is 2980b9.
REQ-033 SHALL check: VideoReady=0 for 10 cycles at x=79 -> Video stays 8e44ad; the first transfer after release gives 2c3e50.
REQ-034 SHALL check: 72 full frames completed -> frame 72 pixel 0 is 1abc9c; frame 144 pixel 0 is 8e44ad.
REQ-035 SHALL check: Mode changed 0->2 at (400,300) -> rest of frame stays tiles; next frame pixel 5 is 050505.
REQ-036 SHALL check: Reset asserted at (123,45) -> next cycle VideoValid=0; after release pixel (0,0) is 8e44ad.
REQ-037 SHALL check, with PATTERN_GEN_SYNC_FLAGS_EN and H_ACTIVE=16, V_ACTIVE=4, TILE_W=4, TILE_H=2 -> StartOfFrame pulses every 64 transfers and EndOfLine every 16.
